// File: rtl/glonass_nav_modulator.sv
// Locks a chip/epoch counter to the ranging-code stream and emits code ^ nav bit ^ meander.
// Outputs register one cycle after each chip strobe; nav bits enter through a one-entry valid/ready buffer.
module glonass_nav_modulator #(
  parameter int CODE_LEN           = 511,
  parameter int EPOCHS_PER_BIT     = 20,
  parameter int EPOCHS_PER_MEANDER = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic chip_en,
  input  logic code_chip,
  input  logic code_epoch,
  input  logic data_in,
  input  logic data_valid,
  output logic data_ready,
  output logic mod_out,
  output logic mod_valid,
  output logic bit_start,
  output logic underrun,
  output logic sync_lost
);

  localparam int CW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int EW = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
  localparam logic [CW-1:0] CHIP_LAST     = CW'(CODE_LEN - 1);
  localparam logic [EW-1:0] EPOCH_LAST    = EW'(EPOCHS_PER_BIT - 1);
  localparam logic [EW-1:0] MEANDER_START = EW'(EPOCHS_PER_MEANDER);

  typedef enum logic {
    SEARCH = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] chip_cnt_q, chip_cnt_d;
  logic [EW-1:0] epoch_cnt_q, epoch_cnt_d;
  logic          next_bit_q, next_bit_d;
  logic          next_full_q, next_full_d;
  logic          cur_bit_q, cur_bit_d;
  logic          data_ready_q, data_ready_d;
  logic          mod_out_q, mod_out_d;
  logic          mod_valid_q, mod_valid_d;
  logic          bit_start_q, bit_start_d;
  logic          underrun_q, underrun_d;
  logic          sync_lost_q, sync_lost_d;

  logic          acquire;
  logic          emit;
  logic          boundary;
  logic          epoch_expected;
  logic          xfer;
  logic          bit_eff;
  logic          meander;
  logic [CW-1:0] chip_use;
  logic [EW-1:0] epoch_use;

  always_comb begin
    state_d        = state_q;
    chip_cnt_d     = chip_cnt_q;
    epoch_cnt_d    = epoch_cnt_q;
    next_bit_d     = next_bit_q;
    next_full_d    = next_full_q;
    cur_bit_d      = cur_bit_q;
    underrun_d     = 1'b0;
    sync_lost_d    = 1'b0;
    acquire        = 1'b0;
    emit           = 1'b0;
    epoch_expected = (chip_cnt_q == '0);

    // chip_cnt_q/epoch_cnt_q hold the position the next chip strobe will occupy
    if (chip_en) begin
      if (state_q == SEARCH) begin
        if (code_epoch) begin
          acquire = 1'b1;
          emit    = 1'b1;
          state_d = RUN;
        end
      end else if (epoch_expected && !code_epoch) begin
        sync_lost_d = 1'b1;
        state_d     = SEARCH;
      end else begin
        emit = 1'b1;
        if (code_epoch && !epoch_expected) begin
          sync_lost_d = 1'b1;
          acquire     = 1'b1;
        end
      end
    end

    chip_use  = acquire ? '0 : chip_cnt_q;
    epoch_use = acquire ? '0 : epoch_cnt_q;
    boundary  = emit && (chip_use == '0) && (epoch_use == '0);

    if (emit) begin
      if (chip_use == CHIP_LAST) begin
        chip_cnt_d  = '0;
        epoch_cnt_d = (epoch_use == EPOCH_LAST) ? '0 : epoch_use + EW'(1);
      end else begin
        chip_cnt_d  = chip_use + CW'(1);
        epoch_cnt_d = epoch_use;
      end
    end else if (state_d == SEARCH) begin
      chip_cnt_d  = '0;
      epoch_cnt_d = '0;
    end

    // Boundary consumes the buffer before any same-cycle transfer lands in it
    bit_eff = cur_bit_q;
    if (boundary) begin
      if (next_full_q) begin
        cur_bit_d   = next_bit_q;
        next_full_d = 1'b0;
      end else begin
        cur_bit_d  = 1'b0;
        underrun_d = 1'b1;
      end
      bit_eff = cur_bit_d;
    end

    xfer = data_valid && data_ready_q;
    if (xfer) begin
      next_full_d = 1'b1;
      next_bit_d  = data_in;
    end
    data_ready_d = !next_full_d;

    meander     = (epoch_use >= MEANDER_START);
    mod_valid_d = emit;
    bit_start_d = boundary;
    mod_out_d   = emit ? (code_chip ^ bit_eff ^ meander) : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SEARCH;
      chip_cnt_q   <= '0;
      epoch_cnt_q  <= '0;
      next_bit_q   <= 1'b0;
      next_full_q  <= 1'b0;
      cur_bit_q    <= 1'b0;
      data_ready_q <= 1'b0;
      mod_out_q    <= 1'b0;
      mod_valid_q  <= 1'b0;
      bit_start_q  <= 1'b0;
      underrun_q   <= 1'b0;
      sync_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      chip_cnt_q   <= chip_cnt_d;
      epoch_cnt_q  <= epoch_cnt_d;
      next_bit_q   <= next_bit_d;
      next_full_q  <= next_full_d;
      cur_bit_q    <= cur_bit_d;
      data_ready_q <= data_ready_d;
      mod_out_q    <= mod_out_d;
      mod_valid_q  <= mod_valid_d;
      bit_start_q  <= bit_start_d;
      underrun_q   <= underrun_d;
      sync_lost_q  <= sync_lost_d;
    end
  end

  assign data_ready = data_ready_q;
  assign mod_out    = mod_out_q;
  assign mod_valid  = mod_valid_q;
  assign bit_start  = bit_start_q;
  assign underrun   = underrun_q;
  assign sync_lost  = sync_lost_q;

endmodule

// File: doc/glonass_nav_modulator.md
# glonass_nav_modulator

Downstream stage of the GLONASS ranging-code generator (9-stage LFSR, x^9 + x^5 + 1, 511 chips per period). It takes the chip stream and a code-epoch marker from the generator and locks a chip/epoch counter to it. It buffers navigation data bits through a valid/ready handshake and emits the modulated chip, computed as code XOR data XOR meander, one cycle after each chip.

## Interface
- CODE_LEN, 511, chips per code period (epoch).
- EPOCHS_PER_BIT, 20, code epochs per navigation data bit.
- EPOCHS_PER_MEANDER, 10, epochs per meander half-period. Must equal EPOCHS_PER_BIT/2.

- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- chip_en  in  1  one-cycle strobe: code_chip/code_epoch valid, generator advanced. Back-to-back strobes allowed.
- code_chip  in  1  current ranging-code chip.
- code_epoch  in  1  qualified by chip_en; high on the first chip of a code period.
- data_in  in  1  navigation data bit.
- data_valid  in  1  data_in offered.
- data_ready  out  1  buffer can accept; a transfer occurs when data_valid & data_ready.
- mod_out  out  1  modulated chip.
- mod_valid  out  1  one-cycle strobe, mod_out valid.
- bit_start  out  1  with mod_valid: first chip of a data bit.
- underrun  out  1  one-cycle pulse: bit boundary reached with empty buffer.
- sync_lost  out  1  one-cycle pulse: epoch marker inconsistent with chip count.

## Operation
- State machine:
  - SEARCH (reset state): chip strobes produce no output.
  - SEARCH -> RUN on chip_en & code_epoch. On that strobe, chip_cnt=0 and epoch_cnt=0, and the strobe is processed as the first chip of a bit.
- Counters in RUN:
  - chip_cnt 0..CODE_LEN-1 increments on each chip_en.
  - When chip_cnt wraps to 0, epoch_cnt increments mod EPOCHS_PER_BIT.
  - Widths are clog2 of the respective parameter.
- Sync check on every chip_en in RUN (expected epoch = wrap to chip 0):
  - Epoch expected and code_epoch=1: normal.
  - Epoch expected and code_epoch=0: pulse sync_lost, go to SEARCH, no mod_valid for this strobe.
  - code_epoch=1 but not expected: pulse sync_lost, stay in RUN, re-acquire exactly as the SEARCH->RUN transition (counts to 0, bit boundary, mod_valid asserted).
- Data buffer:
  - One-entry holding register next_bit/next_full; accepted in any state.
  - data_ready is a registered copy of !next_full after the current cycle's updates.
- Bit boundary: any chip_en in RUN (or re-acquire) with chip_cnt=0 and epoch_cnt=0.
  - next_full=1: cur_bit <= next_bit and next_full cleared.
  - next_full=0: cur_bit <= 0 and underrun pulses.
  - No bypass: a bit accepted in the boundary cycle itself is stored in the buffer for the next bit.
- meander = 0 while epoch_cnt < EPOCHS_PER_MEANDER, else 1.
- mod_out = code_chip ^ cur_bit_effective ^ meander.
  - cur_bit_effective is the newly loaded value on a boundary strobe.
  - meander uses the epoch_cnt value applied to this chip.

## Timing
- Reset values: mod_out=0, mod_valid=0, bit_start=0, underrun=0, sync_lost=0, data_ready=0; state=SEARCH, counters 0, next_full=0, cur_bit=0.
- data_ready rises on the first clk edge after reset deasserts.
- Latency: chip_en at edge k gives mod_out/mod_valid/bit_start registered at edge k+1.
  - underrun and sync_lost are aligned with that mod_valid (same cycle); sync_lost is still asserted even when no mod_valid follows.
- Handshake: a transfer in cycle k makes data_ready=0 from edge k+1. A boundary consume in cycle k makes data_ready=1 from edge k+1.
- Reset asserted mid-operation clears everything immediately, including a pending buffered bit.

## Test plan
Parameters for all scenarios: CODE_LEN=7, EPOCHS_PER_BIT=4, EPOCHS_PER_MEANDER=2.
- Acquisition:
  - Stimulus: chip_en every 3 clks, code_epoch on every 7th chip, buffer preloaded with data_in=1.
  - Required: no mod_valid before the first epoch; first mod_valid has bit_start=1 and mod_out=~code_chip.
  - Required: chips 14..27 (epochs 2..3) give mod_out=code_chip.
- Data streaming:
  - Stimulus: bits 1,0,1,1 fed whenever data_ready.
  - Required: bit_start exactly every 28 chips; each bit spans 28 chips with mod_out = code ^ bit ^ meander; no underrun.
- Underrun:
  - Stimulus: withhold data at the second boundary.
  - Required: underrun pulses once with that bit_start; that bit uses cur_bit=0.
  - Stimulus: a bit offered in the same boundary cycle.
  - Required: that bit appears at the third boundary.
- Missing epoch:
  - Stimulus: drop code_epoch at chip 7.
  - Required: sync_lost pulse and no mod_valid for that strobe; SEARCH until the next code_epoch, then bit_start=1.
- Early epoch:
  - Stimulus: code_epoch at chip_cnt=3.
  - Required: sync_lost and bit_start in the same cycle; counters restart at 0; mod_valid uninterrupted.
- Reset mid-bit:
  - Stimulus: reset asserted with buffer full at chip 10.
  - Required: all outputs 0 at once; data_ready=0 during reset and 1 one edge after release; buffered bit discarded, so the next boundary signals underrun.
